// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter (inhibit, request-to-send, device-clocked shift, ACK check); ports: clk/rst, tx_data/tx_valid/tx_ready request, busy=~tx_ready, ps2_clk_i/ps2_data_i raw lines, ps2_clk_oe/ps2_data_oe pull-low enables, done pulse with err
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int REQ_CYCLES = 16,
  parameter int FIRST_TIMEOUT = 1500000,
  parameter int BIT_TIMEOUT = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err
);
  localparam int MAX_A = INHIBIT_CYCLES > REQ_CYCLES ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_B = FIRST_TIMEOUT > BIT_TIMEOUT ? FIRST_TIMEOUT : BIT_TIMEOUT;
  localparam int MAX_P = MAX_A > MAX_B ? MAX_A : MAX_B;
  localparam int CW = $clog2(MAX_P + 1);
  localparam logic [2:0] IDLE = 3'd0, INHIBIT = 3'd1, REQ = 3'd2, SEND = 3'd3,
                         WAIT_IDLE = 3'd4, DONE = 3'd5, FAIL = 3'd6;
  logic [2:0] state;
  logic [CW-1:0] cnt, limit;
  logic [3:0] bitcnt;
  logic [9:0] sh;
  logic drive_low;
  logic clk_s1, clk_s2, clk_prev, data_s1, data_s2, fall;
  assign fall = clk_prev & ~clk_s2;
  assign limit = (state == SEND && bitcnt == 4'd0) ? CW'(FIRST_TIMEOUT) : CW'(BIT_TIMEOUT);
  assign tx_ready = state == IDLE;
  assign busy = ~tx_ready;
  assign ps2_clk_oe = state == INHIBIT || state == REQ;
  assign ps2_data_oe = state == REQ || (state == SEND && drive_low);
  assign done = state == DONE || state == FAIL;
  assign err = state == FAIL;
  always_ff @(posedge clk) begin
    clk_s1 <= ps2_clk_i;
    clk_s2 <= clk_s1;
    clk_prev <= clk_s2;
    data_s1 <= ps2_data_i;
    data_s2 <= data_s1;
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bitcnt <= '0;
      sh <= '0;
      drive_low <= 1'b0;
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_prev <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      case (state)
        IDLE:
          if (tx_valid) begin
            sh <= {1'b1, ~^tx_data, tx_data};
            cnt <= '0;
            state <= INHIBIT;
          end
        INHIBIT:
          if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
            cnt <= '0;
            state <= REQ;
          end else cnt <= cnt + CW'(1);
        REQ:
          if (cnt == CW'(REQ_CYCLES - 1)) begin
            cnt <= '0;
            bitcnt <= '0;
            drive_low <= 1'b1;
            state <= SEND;
          end else cnt <= cnt + CW'(1);
        SEND:
          if (fall) begin
            cnt <= '0;
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'd10) state <= data_s2 ? FAIL : WAIT_IDLE;
            else begin
              drive_low <= ~sh[0];
              sh <= sh >> 1;
            end
          end else if (cnt == limit) state <= FAIL;
          else cnt <= cnt + CW'(1);
        WAIT_IDLE:
          if (clk_s2 && data_s2) state <= DONE;
          else if (fall) cnt <= '0;
          else if (cnt == limit) state <= FAIL;
          else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule
